// File: rtl/dmem_sized_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
//   Shared encodings and helpers for the sized data-memory controller.
//   - SZ_B / SZ_H / SZ_W / SZ_R : req_size encodings (SZ_R is reserved).
//   - ST_IDLE / ST_WAIT / ST_RESP : controller FSM state codes.
//   - byte_en()     : lane-enable mask for a size and byte offset.
//   - byte_parity() : even-parity bit per byte of a 32-bit word.
// ----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_R = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = 4'b0011 << a;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Stored bit makes each byte plus its parity bit contain an even number of ones.
    function automatic logic [3:0] byte_parity(input logic [31:0] w);
        logic [3:0] p;
        for (int unsigned i = 0; i < 4; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dmem_sized_ctrl_if.sv
// ----------------------------------------------------------------------------
// dmem_sized_ctrl_if
//   Request/response handshake bundle between the MEM-stage LSU (master)
//   and the sized data memory (slave).
//   req_valid/req_ready/req_we/req_addr/req_size/req_uns/req_wdata : request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                          : response
// ----------------------------------------------------------------------------
interface dmem_sized_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_uns, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_uns, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align  (combinational)
//   Store side: replicates right-justified store data across all lanes so the
//   byte enables alone pick the written bytes.
//   Load side: shifts the addressed lane down and sign/zero-extends it.
//   Ports:
//     size      in  2   SZ_B/SZ_H/SZ_W (SZ_R yields zero read data)
//     a_lo      in  2   byte offset within the word
//     uns       in  1   zero-extend loads when 1
//     wdata     in  32  store data, right-justified
//     rword     in  32  raw word read from the array
//     wdata_rep out 32  lane-replicated store data
//     rdata_ext out 32  extracted and extended load data
// ----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rword >> {a_lo, 3'b000};

    always_comb begin
        wdata_rep = '0;
        case (size)
            SZ_B:    wdata_rep = {4{wdata[7:0]}};
            SZ_H:    wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    always_comb begin
        rdata_ext = '0;
        case (size)
            SZ_B:    rdata_ext = {{24{shifted[7]  & ~uns}}, shifted[7:0]};
            SZ_H:    rdata_ext = {{16{shifted[15] & ~uns}}, shifted[15:0]};
            SZ_W:    rdata_ext = rword;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/dmem_sized_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_sized_ctrl
//   RV32 load/store data memory with byte/half/word accesses, sign/zero
//   extended loads, misalignment / out-of-range / reserved-size detection and
//   a single-outstanding valid/ready handshake with LATENCY cycles from
//   accept to response.
//   Parameters: DEPTH (words, power of 2), LATENCY (1..8), INIT_VAL (fill).
//   Ports:
//     clk    in     rising-edge clock
//     rst_n  in     asynchronous active-low reset
//     bus    slave  dmem_sized_ctrl_if request/response bundle
//   Optional macro DMEM_PARITY_EN: per-byte even parity stored with each
//   written lane and checked on the selected lanes of every load.
// ----------------------------------------------------------------------------
module dmem_sized_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned LATENCY  = 1,
    parameter logic [31:0] INIT_VAL = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_sized_ctrl_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH] = '{default: INIT_VAL};
`ifdef DMEM_PARITY_EN
    localparam logic [3:0] INIT_PAR = byte_parity(INIT_VAL);
    logic [3:0] par_mem [DEPTH] = '{default: INIT_PAR};
    logic [3:0] wr_par;
`endif

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    logic          accept;
    logic [1:0]    a_lo;
    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          misaligned;
    logic          addr_err;
    logic          par_err;
    logic          any_err;
    logic [3:0]    be;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [31:0]   wdata_rep;
    logic [31:0]   rdata_ext;

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign accept       = bus.req_valid & bus.req_ready;
    assign a_lo         = bus.req_addr[1:0];
    assign idx          = bus.req_addr[AW+1:2];
    // Any set bit above the index field addresses beyond the array.
    assign out_of_range = |bus.req_addr[31:AW+2];
    assign misaligned   = ((bus.req_size == SZ_H) & a_lo[0]) |
                          ((bus.req_size == SZ_W) & (|a_lo));
    assign addr_err     = out_of_range | misaligned | (bus.req_size == SZ_R);
    assign be           = byte_en(bus.req_size, a_lo);
    assign rd_word      = mem[idx];

`ifdef DMEM_PARITY_EN
    assign par_err = ~bus.req_we & (|((par_mem[idx] ^ byte_parity(rd_word)) & be));
    assign wr_par  = (par_mem[idx] & ~be) | (byte_parity(wdata_rep) & be);
`else
    assign par_err = 1'b0;
`endif

    assign any_err = addr_err | par_err;

    dmem_lane_align u_align (
        .size      (bus.req_size),
        .a_lo      (a_lo),
        .uns       (bus.req_uns),
        .wdata     (bus.req_wdata),
        .rword     (rd_word),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // Read-modify-write merge keeps disabled lanes at their old value.
    always_comb begin
        wr_word = rd_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                wr_word[8*i +: 8] = wdata_rep[8*i +: 8];
            end
        end
    end

    // Array is intentionally outside reset: committed stores survive rst_n.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !addr_err) begin
            mem[idx] <= wr_word;
`ifdef DMEM_PARITY_EN
            par_mem[idx] <= wr_par;
`endif
        end
    end

    // Result is formed at accept; WAIT only delays its visibility.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rsp_err_q   <= any_err;
                        rsp_rdata_q <= (any_err || bus.req_we) ? '0 : rdata_ext;
                        if (LATENCY <= 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 3'(LATENCY - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_sized_ctrl
//   Directed bench for dmem_sized_ctrl: one instance with LATENCY=1 and one
//   with LATENCY=4, both DEPTH=256. Macro DMEM_PARITY_EN enables the parity
//   fault-injection scenario.
// ----------------------------------------------------------------------------
module tb_dmem_sized_ctrl;
    import dmem_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    dmem_sized_ctrl_if if1 ();
    dmem_sized_ctrl_if if4 ();

    dmem_sized_ctrl #(.DEPTH(256), .LATENCY(1), .INIT_VAL(32'hDEADBEEF)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    dmem_sized_ctrl #(.DEPTH(256), .LATENCY(4), .INIT_VAL(32'hDEADBEEF)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request on the selected instance and collects its response.
    // cyc = edges after accept until rsp_valid (LATENCY-1); 99 on timeout.
    task automatic xact(input bit sel4, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int cyc);
        @(negedge clk);
        if (sel4) begin
            if4.req_valid = 1'b1; if4.req_we = we; if4.req_addr = addr;
            if4.req_size = size; if4.req_uns = uns; if4.req_wdata = wdata;
        end else begin
            if1.req_valid = 1'b1; if1.req_we = we; if1.req_addr = addr;
            if1.req_size = size; if1.req_uns = uns; if1.req_wdata = wdata;
        end
        @(posedge clk);
        #1;
        if1.req_valid = 1'b0;
        if4.req_valid = 1'b0;
        cyc = 0;
        while (!(sel4 ? if4.rsp_valid : if1.rsp_valid) && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 20) begin
            cyc   = 99;
            rdata = 'x;
            err   = 1'bx;
        end else begin
            rdata = sel4 ? if4.rsp_rdata : if1.rsp_rdata;
            err   = sel4 ? if4.rsp_err : if1.rsp_err;
            if (sel4) if4.rsp_ready = 1'b1; else if1.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            if1.rsp_ready = 1'b0;
            if4.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (if1.req_ready !== 1'b1 || if4.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b/%b expected 1/1", if1.req_ready, if4.req_ready);
        end
        n_checks++;
        if (if1.rsp_valid !== 1'b0 || if4.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: got %b/%b expected 0/0", if1.rsp_valid, if4.rsp_valid);
        end
        n_checks++;
        if (if1.rsp_rdata !== 32'h0 || if1.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_data: got %h/%b expected 00000000/0", if1.rsp_rdata, if1.rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        logic [31:0] rd; logic er; int cyc;
        xact(1'b0, 1'b0, 32'h000, SZ_W, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (cyc !== 0) begin
            n_fail++;
            $display("FAIL lw0_latency: got %0d expected 0", cyc);
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lw0_data: got %h/%b expected deadbeef/0", rd, er);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int cyc;
        logic [31:0] exp_rd [3] = '{32'hA5ADBEEF, 32'hFFFFFFA5, 32'h000000A5};
        logic [31:0] addr_t [3] = '{32'h100, 32'h103, 32'h103};
        logic [1:0]  size_t [3] = '{SZ_W, SZ_B, SZ_B};
        logic        uns_t  [3] = '{1'b0, 1'b0, 1'b1};
        xact(1'b0, 1'b1, 32'h103, SZ_B, 1'b0, 32'h000000A5, rd, er, cyc);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0 || cyc !== 0) begin
            n_fail++;
            $display("FAIL sb_rsp: got %h/%b/%0d expected 00000000/0/0", rd, er, cyc);
        end
        for (int i = 0; i < 3; i++) begin
            xact(1'b0, 1'b0, addr_t[i], size_t[i], uns_t[i], 32'h0, rd, er, cyc);
            n_checks++;
            if (rd !== exp_rd[i] || er !== 1'b0) begin
                n_fail++;
                $display("FAIL byte_load%0d: got %h/%b expected %h/0", i, rd, er, exp_rd[i]);
            end
        end
    endtask

    task automatic test_half_misalign();
        logic [31:0] rd; logic er; int cyc;
        logic [31:0] exp_rd [5] = '{32'hFFFF8234, 32'h00008234, 32'hFFFFFFEF, 32'h000000BE, 32'h8234BEEF};
        logic [31:0] addr_t [5] = '{32'h202, 32'h202, 32'h200, 32'h201, 32'h200};
        logic [1:0]  size_t [5] = '{SZ_H, SZ_H, SZ_B, SZ_B, SZ_W};
        logic        uns_t  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        xact(1'b0, 1'b1, 32'h202, SZ_H, 1'b0, 32'h00008234, rd, er, cyc);
        xact(1'b0, 1'b1, 32'h201, SZ_W, 1'b0, 32'h11111111, rd, er, cyc);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL sw_misaligned: got err %b rdata %h expected 1/00000000", er, rd);
        end
        for (int i = 0; i < 5; i++) begin
            xact(1'b0, 1'b0, addr_t[i], size_t[i], uns_t[i], 32'h0, rd, er, cyc);
            n_checks++;
            if (rd !== exp_rd[i] || er !== 1'b0) begin
                n_fail++;
                $display("FAIL half_load%0d: got %h/%b expected %h/0", i, rd, er, exp_rd[i]);
            end
        end
        xact(1'b0, 1'b0, 32'h201, SZ_W, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0 || cyc !== 0) begin
            n_fail++;
            $display("FAIL lw_misaligned: got %h/%b/%0d expected 00000000/1/0", rd, er, cyc);
        end
        xact(1'b0, 1'b0, 32'h203, SZ_H, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL lh_misaligned: got %h/%b expected 00000000/1", rd, er);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int cyc;
        xact(1'b0, 1'b0, 32'h400, SZ_W, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL lw_oor: got %h/%b expected 00000000/1", rd, er);
        end
        xact(1'b0, 1'b1, 32'h400, SZ_W, 1'b0, 32'h12345678, rd, er, cyc);
        n_checks++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_oor_err: got %b expected 1", er);
        end
        xact(1'b0, 1'b0, 32'h000, SZ_W, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_oor_alias: got %h/%b expected deadbeef/0", rd, er);
        end
        xact(1'b0, 1'b0, 32'h3FC, SZ_W, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_last_word: got %h/%b expected deadbeef/0", rd, er);
        end
        xact(1'b0, 1'b0, 32'h000, SZ_R, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_size: got %h/%b expected 00000000/1", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int cyc;
        xact(1'b0, 1'b1, 32'h300, SZ_W, 1'b0, 32'h11223344, rd, er, cyc);
        xact(1'b0, 1'b0, 32'h302, SZ_H, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (rd !== 32'h00001122 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_lh: got %h/%b expected 00001122/0", rd, er);
        end
        xact(1'b0, 1'b1, 32'h301, SZ_B, 1'b0, 32'hFFFFFF99, rd, er, cyc);
        xact(1'b0, 1'b0, 32'h300, SZ_W, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (rd !== 32'h11229944 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_sb_lw: got %h/%b expected 11229944/0", rd, er);
        end
    endtask

    task automatic test_latency_backpressure();
        @(negedge clk);
        n_checks++;
        if (if4.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL l4_ready_idle: got %b expected 1", if4.req_ready);
        end
        if4.req_valid = 1'b1; if4.req_we = 1'b0; if4.req_addr = 32'h010;
        if4.req_size = SZ_W; if4.req_uns = 1'b0; if4.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        if4.req_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (if4.rsp_valid !== 1'b0 || if4.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL l4_wait_e%0d: valid %b ready %b expected 0/0", i, if4.rsp_valid, if4.req_ready);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (if4.rsp_valid !== 1'b1 || if4.rsp_rdata !== 32'hDEADBEEF || if4.rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL l4_rsp_e3: valid %b data %h err %b expected 1/deadbeef/0",
                     if4.rsp_valid, if4.rsp_rdata, if4.rsp_err);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (if4.rsp_valid !== 1'b1 || if4.rsp_rdata !== 32'hDEADBEEF || if4.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL l4_hold%0d: valid %b data %h ready %b expected 1/deadbeef/0",
                         i, if4.rsp_valid, if4.rsp_rdata, if4.req_ready);
            end
        end
        @(negedge clk);
        if4.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        if4.rsp_ready = 1'b0;
        n_checks++;
        if (if4.rsp_valid !== 1'b0 || if4.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL l4_release: valid %b ready %b expected 0/1", if4.rsp_valid, if4.req_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic er; int cyc;
        @(negedge clk);
        if4.req_valid = 1'b1; if4.req_we = 1'b1; if4.req_addr = 32'h024;
        if4.req_size = SZ_W; if4.req_uns = 1'b0; if4.req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        if4.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (if4.rsp_valid !== 1'b0 || if4.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_wait: valid %b ready %b expected 0/1", if4.rsp_valid, if4.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (if4.rsp_valid !== 1'b0 || if4.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after_release: valid %b ready %b expected 0/1", if4.rsp_valid, if4.req_ready);
        end
        xact(1'b1, 1'b0, 32'h024, SZ_W, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0 || cyc !== 3) begin
            n_fail++;
            $display("FAIL rst_store_kept: got %h/%b/%0d expected cafef00d/0/3", rd, er, cyc);
        end
    endtask

`ifdef DMEM_PARITY_EN
    task automatic test_parity();
        logic [31:0] rd; logic er; int cyc;
        logic [31:0] w;
        @(negedge clk);
        w = u1.mem[48];
        w[0] = ~w[0];
        u1.mem[48] = w;
        xact(1'b0, 1'b0, 32'h0C0, SZ_B, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL parity_bad_lane: got %h/%b expected 00000000/1", rd, er);
        end
        xact(1'b0, 1'b0, 32'h0C1, SZ_B, 1'b0, 32'h0, rd, er, cyc);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'hFFFFFFBE) begin
            n_fail++;
            $display("FAIL parity_good_lane: got %h/%b expected ffffffbe/0", rd, er);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        if1.req_valid = 1'b0; if1.req_we = 1'b0; if1.req_addr = '0; if1.req_size = SZ_W;
        if1.req_uns = 1'b0; if1.req_wdata = '0; if1.rsp_ready = 1'b0;
        if4.req_valid = 1'b0; if4.req_we = 1'b0; if4.req_addr = '0; if4.req_size = SZ_W;
        if4.req_uns = 1'b0; if4.req_wdata = '0; if4.rsp_ready = 1'b0;

        test_reset();
        test_basic_load();
        test_byte();
        test_half_misalign();
        test_range();
        test_back_to_back();
        test_latency_backpressure();
        test_reset_mid_wait();
`ifdef DMEM_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
